// File: rtl/bank_row_writer.sv
// Streaming ASCII parser for the battery-bank puzzle: packs each text line into
// a BCD row (MSD first) and writes it into the bank row memory.
module bank_row_writer #(
  parameter int MAX_DIGITS = 100,
  parameter int ROWS       = 200,
  parameter int ADDR_W     = 8,
  parameter int LEN_W      = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [4*MAX_DIGITS-1:0] wr_data,
  output logic [LEN_W-1:0]        wr_len,
  output logic [ADDR_W-1:0]       row_count,
  output logic                    done,
  output logic                    err_char,
  output logic                    err_overflow,
  output logic                    err_rows
);

  localparam int DW = 4 * MAX_DIGITS;

  typedef enum logic [1:0] {RX, WRITE, DONE} state_t;

  state_t            state_q;
  logic [DW-1:0]     shift_q, shift_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              last_q;
  logic              in_ready_q, wr_en_q, done_q;
  logic [ADDR_W-1:0] wr_addr_q, row_count_q;
  logic [DW-1:0]     wr_data_q;
  logic [LEN_W-1:0]  wr_len_q;
  logic              err_char_q, err_overflow_q, err_rows_q;

  logic accept, is_digit, is_lf, is_cr;
  logic set_char, set_ovf, go_write, go_done, row_full;

  always_comb begin
    accept   = in_valid && in_ready_q && (state_q == RX);
    is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    is_lf    = (in_data == 8'h0A);
    is_cr    = (in_data == 8'h0D);
    shift_d  = shift_q;
    count_d  = count_q;
    set_char = 1'b0;
    set_ovf  = 1'b0;
    if (is_digit) begin
      if (int'(count_q) < MAX_DIGITS) begin
        shift_d = {shift_q[DW-5:0], in_data[3:0]};
        count_d = count_q + LEN_W'(1);
      end else begin
        set_ovf = 1'b1;
      end
    end else if (!is_lf && !is_cr) begin
      set_char = 1'b1;
    end
    // A final byte flushes any pending digits even without a closing newline.
    go_write = (is_lf && (count_q != '0)) || (in_last && (count_d != '0));
    go_done  = in_last && !go_write;
    row_full = int'(row_count_q) >= ROWS;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RX;
      shift_q        <= '0;
      count_q        <= '0;
      last_q         <= 1'b0;
      in_ready_q     <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_len_q       <= '0;
      row_count_q    <= '0;
      done_q         <= 1'b0;
      err_char_q     <= 1'b0;
      err_overflow_q <= 1'b0;
      err_rows_q     <= 1'b0;
    end else begin
      case (state_q)
        RX: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            shift_q        <= shift_d;
            count_q        <= count_d;
            err_char_q     <= err_char_q | set_char;
            err_overflow_q <= err_overflow_q | set_ovf;
            if (go_write) begin
              state_q    <= WRITE;
              in_ready_q <= 1'b0;
              last_q     <= in_last;
              // With the memory full the row is dropped but WRITE still takes its cycle.
              if (row_full) begin
                err_rows_q <= 1'b1;
              end else begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= row_count_q;
                wr_data_q <= shift_d;
                wr_len_q  <= count_d;
              end
            end else if (go_done) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        WRITE: begin
          wr_en_q <= 1'b0;
          if (wr_en_q) row_count_q <= row_count_q + ADDR_W'(1);
          shift_q <= '0;
          count_q <= '0;
          if (last_q) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end else begin
            state_q    <= RX;
            in_ready_q <= 1'b1;
          end
        end
        DONE: begin
          in_ready_q <= 1'b0;
        end
        default: begin
          state_q <= RX;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_len       = wr_len_q;
  assign row_count    = row_count_q;
  assign done         = done_q;
  assign err_char     = err_char_q;
  assign err_overflow = err_overflow_q;
  assign err_rows     = err_rows_q;

endmodule
